output_controler: RTL and testbench

//  Output-port side of one NoC router port; counterpart to the per-input XY controllers.

---
 rtl/output_controler_pkg.sv | 26 ++
 rtl/output_controler_rr_arbiter.sv | 32 +++
 rtl/output_controler.sv | 96 +++++++++
 tb/tb_output_controler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_controler_pkg.sv
// rtl/output_controler_pkg.sv - shared route codes, port count and flit field positions
// Route codes are the 3-bit values the per-input XY controllers present to each output.
package output_controler_pkg;

  localparam int ROUTE_W   = 3;
  localparam int NUM_PORTS = 5;

  typedef enum logic [ROUTE_W-1:0] {
    LOCAL        = 3'b000,
    EAST         = 3'b001,
    WEST         = 3'b010,
    NORTH        = 3'b011,
    SOUTH        = 3'b100,
    NOT_REGISTER = 3'b111
  } route_e;

  localparam int X_DES_LSB = 0;
  localparam int Y_DES_LSB = 2;
  localparam int DES_W     = 2;

  // Destination pair {y_des, x_des}; the output side carries these bits through untouched.
  function automatic logic [2*DES_W-1:0] flit_dest(input logic [7:0] flit);
    return {flit[Y_DES_LSB +: DES_W], flit[X_DES_LSB +: DES_W]};
  endfunction

endpackage

// File: rtl/output_controler_rr_arbiter.sv
// rtl/output_controler_rr_arbiter.sv - round-robin arbiter over the input controllers
// Grants the first requester found scanning from i_rr_ptr upward, modulo N_IN.
module output_controler_rr_arbiter #(
  parameter int N_IN = 5,
  parameter int PW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN-1:0] i_req,
  input  logic            i_en,
  input  logic [PW-1:0]   i_rr_ptr,
  output logic [N_IN-1:0] o_gnt,
  output logic [PW-1:0]   o_winner
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_gnt    = '0;
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_idx = PW'((int'(i_rr_ptr) + k) % N_IN);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_winner     = w_idx;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_controler.sv
// rtl/output_controler.sv - NoC router output port: collect, arbitrate, buffer, forward
// Flits whose route code matches PORT_ID are acked round-robin and queued for the downstream link.
module output_controler
  import output_controler_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    N_REGISTER = ROUTE_W,
  parameter int                    N_IN       = NUM_PORTS,
  parameter int                    DEPTH      = 4,
  parameter logic [N_REGISTER-1:0] PORT_ID    = N_REGISTER'(LOCAL)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_IN*N_REGISTER-1:0]   reg_in,
  input  logic [N_IN*DATA_WIDTH-1:0]   data_in,
  output logic [N_IN-1:0]              ack,
  input  logic                         down_full,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         write,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [N_REGISTER-1:0] NO_ROUTE = N_REGISTER'(NOT_REGISTER);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_rr_ptr;

  logic [N_IN-1:0]       w_req;
  logic                  w_accept;
  logic [N_IN-1:0]       w_gnt;
  logic [PW-1:0]         w_winner;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_write;

  for (genvar i = 0; i < N_IN; i++) begin : g_req
    assign w_req[i] = (reg_in[i*N_REGISTER +: N_REGISTER] == PORT_ID) &&
                      (reg_in[i*N_REGISTER +: N_REGISTER] != NO_ROUTE);
  end

  // Full blocks acceptance even when a pop happens the same cycle; reset forces ack low.
  assign w_accept = (|w_req) && (r_count < CW'(DEPTH)) && !rst;

  output_controler_rr_arbiter #(
    .N_IN (N_IN),
    .PW   (PW)
  ) u_arb (
    .i_req    (w_req),
    .i_en     (w_accept),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_gnt),
    .o_winner (w_winner)
  );

  assign w_push_data = data_in[w_winner*DATA_WIDTH +: DATA_WIDTH];
  assign w_write     = (r_count != '0) && !down_full;

  assign ack      = w_gnt;
  assign write    = w_write;
  assign count    = r_count;
  assign data_out = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_winner == PW'(N_IN - 1)) ? '0 : w_winner + 1'b1;
      end
      if (w_write) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_accept && !w_write) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_write) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_controler.sv
// tb/tb_output_controler.sv - self-checking bench for output_controler
// Queue-based reference model plus constant tables and directed corner sequences.
module tb_output_controler;

  localparam int DW    = 8;
  localparam int NR    = 3;
  localparam int NI    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [2:0] PID = 3'b001;

  logic            clk = 1'b0;
  logic            rst;
  logic [NI*NR-1:0] reg_in;
  logic [NI*DW-1:0] data_in;
  logic [NI-1:0]   ack;
  logic            down_full;
  logic [DW-1:0]   data_out;
  logic            write;
  logic [CW-1:0]   count;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  int         m_rr = 0;
  logic [7:0] got[$];

  logic [NI-1:0] s_ack;
  logic          s_write;
  logic [7:0]    s_dout;
  logic [CW-1:0] s_count;

  typedef struct {
    logic [NI*NR-1:0] r;
    logic [NI*DW-1:0] d;
    logic             df;
    logic [NI-1:0]    a;
    logic             w;
    logic [7:0]       o;
    logic [CW-1:0]    c;
  } vec_t;
  vec_t tbl[6];

  output_controler #(
    .DATA_WIDTH (DW),
    .N_REGISTER (NR),
    .N_IN       (NI),
    .DEPTH      (DEPTH),
    .PORT_ID    (PID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_in    (reg_in),
    .data_in   (data_in),
    .ack       (ack),
    .down_full (down_full),
    .data_out  (data_out),
    .write     (write),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NI-1:0] m_ack();
    logic [NI-1:0] a;
    a = '0;
    if (mq.size() < DEPTH) begin
      for (int k = 0; k < NI; k++) begin
        int i;
        i = (m_rr + k) % NI;
        if (reg_in[i*NR +: NR] == PID) begin
          a[i] = 1'b1;
          break;
        end
      end
    end
    return a;
  endfunction

  // Sample at the negedge, compare against the model, then advance the model by one edge.
  task automatic tick(input string tag);
    logic [NI-1:0] ea;
    logic          ew;
    logic [7:0]    ed;
    @(negedge clk);
    s_ack = ack; s_write = write; s_dout = data_out; s_count = count;
    ea = m_ack();
    ew = (mq.size() != 0) && !down_full;
    ed = (mq.size() != 0) ? mq[0] : 8'h00;
    chk({tag, " ack"}, 64'(ack), 64'(ea));
    chk({tag, " write"}, 64'(write), 64'(ew));
    chk({tag, " data_out"}, 64'(data_out), 64'(ed));
    chk({tag, " count"}, 64'(count), 64'(mq.size()));
    if (write) got.push_back(data_out);
    if (ew) void'(mq.pop_front());
    for (int i = 0; i < NI; i++) begin
      if (ea[i]) begin
        mq.push_back(data_in[i*DW +: DW]);
        m_rr = (i + 1) % NI;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    m_rr = 0;
    #1;
    chk("reset ack", 64'(ack), 64'(0));
    chk("reset write", 64'(write), 64'(0));
    chk("reset data_out", 64'(data_out), 64'(0));
    chk("reset count", 64'(count), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
  endtask

  task automatic idle_inputs();
    reg_in    = '1;
    data_in   = '0;
    down_full = 1'b0;
  endtask

  initial begin
    logic [7:0] vals [5];
    int         vi;
    logic [NI-1:0] la;

    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single flit through, then non-matching / no-route codes only.
    tbl[0] = '{r: {3'b111, 3'b111, 3'b001, 3'b111, 3'b111},
               d: {8'h00, 8'h00, 8'hA5, 8'h00, 8'h00}, df: 1'b0,
               a: 5'b00100, w: 1'b0, o: 8'h00, c: 3'd0};
    tbl[1] = '{r: '1, d: '0, df: 1'b0, a: 5'b00000, w: 1'b1, o: 8'hA5, c: 3'd1};
    tbl[2] = '{r: '1, d: '0, df: 1'b0, a: 5'b00000, w: 1'b0, o: 8'h00, c: 3'd0};
    tbl[3] = '{r: {3'b010, 3'b111, 3'b010, 3'b111, 3'b010}, d: '1, df: 1'b0,
               a: 5'b00000, w: 1'b0, o: 8'h00, c: 3'd0};
    tbl[4] = '{r: {3'b111, 3'b010, 3'b111, 3'b010, 3'b111}, d: '1, df: 1'b1,
               a: 5'b00000, w: 1'b0, o: 8'h00, c: 3'd0};
    tbl[5] = '{r: {3'b010, 3'b010, 3'b010, 3'b010, 3'b010}, d: '1, df: 1'b0,
               a: 5'b00000, w: 1'b0, o: 8'h00, c: 3'd0};
    for (int i = 0; i < 6; i++) begin
      reg_in = tbl[i].r; data_in = tbl[i].d; down_full = tbl[i].df;
      tick("tbl");
      chk($sformatf("tbl%0d ack", i), 64'(s_ack), 64'(tbl[i].a));
      chk($sformatf("tbl%0d write", i), 64'(s_write), 64'(tbl[i].w));
      chk($sformatf("tbl%0d data_out", i), 64'(s_dout), 64'(tbl[i].o));
      chk($sformatf("tbl%0d count", i), 64'(s_count), 64'(tbl[i].c));
    end

    // All five inputs request continuously: grants rotate 0..4 then wrap.
    idle_inputs();
    do_reset();
    for (int i = 0; i < NI; i++) begin
      reg_in[i*NR +: NR] = PID;
      data_in[i*DW +: DW] = 8'(8'h10 * i);
    end
    for (int k = 0; k < 6; k++) begin
      tick("rr");
      chk($sformatf("rr ack%0d", k), 64'(s_ack), 64'(5'b00001 << (k % NI)));
      for (int i = 0; i < NI; i++)
        if (s_ack[i]) data_in[i*DW +: DW] = 8'(data_in[i*DW +: DW] + 1);
    end

    // down_full held: four accepted, fifth waits; release drains in order.
    idle_inputs();
    do_reset();
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    vi = 0;
    down_full = 1'b1;
    reg_in[0 +: NR] = PID;
    data_in[0 +: DW] = vals[0];
    for (int k = 0; k < 7; k++) begin
      tick("full");
      if (s_ack[0]) begin
        vi++;
        if (vi < 5) data_in[0 +: DW] = vals[vi];
        else reg_in[0 +: NR] = 3'b111;
      end
    end
    chk("full count", 64'(s_count), 64'(4));
    chk("full no ack", 64'(s_ack), 64'(0));
    down_full = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick("drain");
      if (s_ack[0]) begin
        vi++;
        reg_in[0 +: NR] = 3'b111;
      end
    end
    chk("drain count", 64'(got.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      chk($sformatf("drain order%0d", i), 64'((i < got.size()) ? got[i] : 8'hxx), 64'(vals[i]));

    // count=3 push+pop keeps 3; count=4 with pop gives no ack.
    idle_inputs();
    do_reset();
    down_full = 1'b1;
    reg_in[0 +: NR] = PID;
    data_in[0 +: DW] = 8'h01;
    for (int k = 0; k < 3; k++) begin
      tick("fill3");
      if (s_ack[0]) data_in[0 +: DW] = 8'(data_in[0 +: DW] + 1);
    end
    down_full = 1'b0;
    tick("pp3");
    chk("pp3 count", 64'(s_count), 64'(3));
    chk("pp3 ack", 64'(s_ack), 64'(5'b00001));
    chk("pp3 write", 64'(s_write), 64'(1));
    if (s_ack[0]) data_in[0 +: DW] = 8'(data_in[0 +: DW] + 1);
    down_full = 1'b1;
    tick("after pp3");
    chk("after pp3 count", 64'(s_count), 64'(3));
    if (s_ack[0]) data_in[0 +: DW] = 8'(data_in[0 +: DW] + 1);
    tick("at4");
    chk("at4 count", 64'(s_count), 64'(4));
    down_full = 1'b0;
    tick("pop4");
    chk("pop4 ack", 64'(s_ack), 64'(0));
    chk("pop4 write", 64'(s_write), 64'(1));

    // Asynchronous reset with three flits buffered and a request pending.
    idle_inputs();
    do_reset();
    down_full = 1'b1;
    reg_in[0 +: NR] = PID;
    data_in[0 +: DW] = 8'h77;
    for (int k = 0; k < 3; k++) tick("pre_rst");
    chk("pre_rst count", 64'(count), 64'(3));
    down_full = 1'b0;
    #2;
    rst = 1'b1;
    mq.delete();
    m_rr = 0;
    #1;
    chk("midrst count", 64'(count), 64'(0));
    chk("midrst write", 64'(write), 64'(0));
    chk("midrst ack", 64'(ack), 64'(0));
    chk("midrst data_out", 64'(data_out), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic; requesters hold their flit until acked.
    idle_inputs();
    do_reset();
    la = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NI; i++) begin
        if (la[i] || reg_in[i*NR +: NR] != PID) begin
          case ($urandom_range(0, 3))
            0:       reg_in[i*NR +: NR] = 3'b111;
            1, 2:    reg_in[i*NR +: NR] = PID;
            default: reg_in[i*NR +: NR] = 3'($urandom_range(0, 4));
          endcase
          data_in[i*DW +: DW] = 8'($urandom);
        end
      end
      down_full = ($urandom_range(0, 9) < 3);
      tick("rand");
      la = s_ack;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
